dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
// Shares the single-port DATA_MEMORY between two requesters: port 0 = core data port
// (dAddress/dWriteData/MemRead/MemWrite), port 1 = test/program loader or DMA.
// Arbitrates with round-robin (or fixed priority), sequences each access through a
// 3-state FSM and returns one ack pulse, plus read data, to the winning requester.
// Sits between procedures/loader and DATA_MEMORY in the top level.
// PARAMETERS
// ADDR_W   9    word/byte address width driven to DATA_MEMORY.addr
// DATA_W   32   data width of din/dout
// RR_EN    1    1 = round-robin on contention; 0 = fixed priority, port 0 wins
// PORTS
// clk        in   1       system clock, all state on rising edge
// rst        in   1       asynchronous, active-low reset
// m0_req     in   1       port 0 access request (level, held until m0_ack)
// m0_we      in   1       port 0: 1 = write, 0 = read
// m0_addr    in   ADDR_W  port 0 address
// m0_wdata   in   DATA_W  port 0 write data
// m0_ack     out  1       port 0 completion pulse, 1 cycle
// m0_rdata   out  DATA_W  port 0 read data, valid while m0_ack=1
// m1_req/m1_we/m1_addr/m1_wdata/m1_ack/m1_rdata   same as port 0, for port 1
// ram_we     out  1       to DATA_MEMORY.we
// ram_addr   out  ADDR_W  to DATA_MEMORY.addr
// ram_din    out  DATA_W  to DATA_MEMORY.din
// ram_dout   in   DATA_W  from DATA_MEMORY.dout; valid cycle after addr presented
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, last_gnt=1 (so port 0 wins first tie), captured
//   addr/wdata/we=0, ram_we=0, ram_addr=0, ram_din=0, m0_ack=m1_ack=0, rdata=0.
//   ram_we is decoded from state, so it drops in the same instant rst asserts.
// - FSM: IDLE -> ISSUE -> RESP -> IDLE. No other transitions.
//   IDLE: sample m0_req/m1_req. None -> stay. One -> grant it. Both -> RR_EN=1: grant
//     port != last_gnt; RR_EN=0: grant port 0. On grant: capture we/addr/wdata of
//     winner into registers, set gnt, update last_gnt, go ISSUE.
//   ISSUE: ram_addr=cap_addr, ram_din=cap_wdata, ram_we=cap_we (only state where
//     ram_we may be 1). Go RESP.
//   RESP: m<gnt>_ack=1, m<gnt>_rdata=ram_dout (reads; writes: rdata don't-care, ack
//     still pulses). Other port's ack=0. Go IDLE.
// - Latency: req high in IDLE at edge N -> ISSUE cycle N+1 -> ack during cycle N+2.
//   Throughput 1 access per 3 cycles; requests sampled only in IDLE.
// - Requester protocol: hold req/we/addr/wdata stable until ack; deassert req in the
//   cycle after ack, else the still-high req is a new request next IDLE.
// - Req dropped after grant: transaction already captured, completes, ack still pulses.
// - Losing requester keeps req high; it is served next IDLE (RR guarantees <=1 wait
//   transaction with RR_EN=1; RR_EN=0 port 1 may starve, by design).
// - ram_addr/ram_din hold last driven values outside ISSUE; ram_we=0 outside ISSUE.
// - Reset mid-ISSUE aborts the write (ram_we deasserts asynchronously); no ack issued.
// STRUCTURE
// - Shared include mem_pkg.vh: ADDR_W/DATA_W defaults, FSM state encodings
//   (ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_RESP=2'd2), port index constants.
// - One sub-module: rr_arb2 (2-way grant logic + last_gnt register, RR_EN param).
//   FSM, capture registers and ack/rdata muxing stay in dmem_arbiter.
// TESTING
// - Reset: drive rst=0 mid-run with req pending -> all outputs 0, state IDLE, no ack.
// - Port 0 write 0xDEADBEEF @0x010, then read @0x010 -> ram_we=1 only in ISSUE,
//   m0_ack at cycle N+2, m0_rdata=0xDEADBEEF.
// - Both req in same IDLE, RR_EN=1, after reset -> port 0 acked first, port 1 acked
//   3 cycles later; repeat contention -> grants alternate 0,1,0,1.
// - RR_EN=0, both requesting continuously -> only port 0 acked; m1_ack never 1.
// - Port 1 writes 0x00000055 @0x1FF, drops req in ISSUE -> write still lands,
//   m1_ack pulses once; subsequent port 0 read @0x1FF returns 0x00000055.
// - Reset asserted during ISSUE of write 0x12345678 @0x020 -> ram_we low immediately;
//   later read @0x020 returns prior contents, not 0x12345678.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter: default widths,
// FSM state encoding and requester port indices.
package dmem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 9;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way grant decision with a last-grant register; round-robin on contention
// when RR_EN=1, fixed priority to port 0 otherwise.
module rr_arb2
  import dmem_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_en,
  output logic o_valid,
  output logic o_gnt
);

  logic r_last_gnt;
  logic w_valid;
  logic w_gnt;

  always_comb begin
    w_valid = i_req0 | i_req1;
    w_gnt   = PORT0;
    if (i_req0 && i_req1) begin
      w_gnt = RR_EN ? ~r_last_gnt : PORT0;
    end else if (i_req1) begin
      w_gnt = PORT1;
    end
  end

  // Reset to port 1 so the first tie goes to port 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_gnt <= PORT1;
    end else if (i_en && w_valid) begin
      r_last_gnt <= w_gnt;
    end
  end

  assign o_valid = w_valid;
  assign o_gnt   = w_gnt;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port DATA_MEMORY between the core data port (0) and a loader/DMA
// port (1): IDLE -> ISSUE -> RESP per access, one ack pulse to the winner.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t            r_state;
  logic              r_gnt;
  logic              r_cap_we;
  logic [ADDR_W-1:0] r_cap_addr;
  logic [DATA_W-1:0] r_cap_wdata;
  logic              r_m0_ack;
  logic              r_m1_ack;
  logic              w_arb_valid;
  logic              w_arb_gnt;
  logic              w_idle;

  assign w_idle = (r_state == ST_IDLE);

  rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .i_req0 (m0_req),
    .i_req1 (m1_req),
    .i_en   (w_idle),
    .o_valid(w_arb_valid),
    .o_gnt  (w_arb_gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_gnt       <= PORT0;
      r_cap_we    <= 1'b0;
      r_cap_addr  <= '0;
      r_cap_wdata <= '0;
      r_m0_ack    <= 1'b0;
      r_m1_ack    <= 1'b0;
    end else begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_arb_valid) begin
            r_gnt       <= w_arb_gnt;
            r_cap_we    <= (w_arb_gnt == PORT1) ? m1_we    : m0_we;
            r_cap_addr  <= (w_arb_gnt == PORT1) ? m1_addr  : m0_addr;
            r_cap_wdata <= (w_arb_gnt == PORT1) ? m1_wdata : m0_wdata;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Ack is registered here so it is high for exactly the RESP cycle.
          r_m0_ack <= (r_gnt == PORT0);
          r_m1_ack <= (r_gnt == PORT1);
          r_state  <= ST_RESP;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Capture registers only change on the IDLE->ISSUE edge, so they double as
  // the held address/data bus; ram_we is state-decoded to drop with reset.
  assign ram_we   = (r_state == ST_ISSUE) && r_cap_we;
  assign ram_addr = r_cap_addr;
  assign ram_din  = r_cap_wdata;

  assign m0_ack   = r_m0_ack;
  assign m1_ack   = r_m1_ack;
  assign m0_rdata = r_m0_ack ? ram_dout : '0;
  assign m1_rdata = r_m1_ack ? ram_dout : '0;

endmodule
